multicycle_cpu: RTL and testbench

Parametrised successor of the single-cycle CPU top. All control is generated internally by a multicycle FSM instead of externally driven select pins. One memory port with a req/ready handshake serves both instruction and data access. Register file, ALU, switch input and display output are all inside the block.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/cpu_alu.sv | 40 ++++
 rtl/multicycle_cpu.sv | 240 ++++++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, R-type functs,
// FSM states and ALU operation codes.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_IN    = 6'h3C;
    localparam logic [5:0] OP_OUT   = 6'h3D;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        STOP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub with signed-overflow flag, logic ops,
// signed set-less-than and shamt-driven logical shifts of operand b.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_t                  op,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic        [4:0]        shamt,
    output logic signed [DATA_W-1:0] y,
    output logic                     zero,
    output logic                     ovf
);

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin
                y   = a + b;
                ovf = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                y   = a - b;
                ovf = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = (a < b) ? DATA_W'(1) : '0;
            // Shift amounts at or beyond the word width flush to zero.
            ALU_SLL: y = (int'(shamt) >= DATA_W) ? '0 : (b << shamt);
            ALU_SRL: y = (int'(shamt) >= DATA_W) ? '0 : (b >> shamt);
            default: y = '0;
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle CPU with one shared req/ready memory port and an internal FSM.
// Define OVF_TRAP_EN to trap signed ADD/SUB/ADDI overflow into STOP (adds port ovf).
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 16,
    parameter int                NREGS  = 32,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic [15:0]       switches,
    output logic [DATA_W-1:0] display,
    output logic              display_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef OVF_TRAP_EN
    ,
    output logic              ovf
`endif
);

    state_t                   state;
    logic [31:0]              ir;
    logic signed [DATA_W-1:0] a_reg, b_reg, res;
    logic [DATA_W-1:0]        regs [NREGS];

    logic [5:0]               op, funct;
    logic [4:0]               rs, rt, rd, shamt, wb_idx;
    logic [15:0]              imm;
    logic signed [DATA_W-1:0] imm_sext, alu_b, alu_y;
    logic                     alu_zero, alu_ovf, r_alu;
    alu_op_t                  alu_op;
    logic [ADDR_W-1:0]        npc;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign imm_sext = DATA_W'($signed(imm));

    function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= NREGS)
            return '0;
        return regs[idx];
    endfunction

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = b_reg;
        r_alu  = 1'b0;
        case (op)
            OP_RTYPE: begin
                r_alu = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: r_alu  = 1'b0;
                endcase
            end
            OP_ADDI: alu_b = imm_sext;
            OP_BEQ, OP_BNE: alu_op = ALU_SUB;
            default: ;
        endcase
    end

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (alu_op),
        .a     (a_reg),
        .b     (alu_b),
        .shamt (shamt),
        .y     (alu_y),
        .zero  (alu_zero),
        .ovf   (alu_ovf)
    );

`ifndef OVF_TRAP_EN
    logic unused_alu_ovf;
    assign unused_alu_ovf = alu_ovf;
`endif

    // pc already holds pc+1 by EXEC, so branch offsets are relative to it.
    always_comb begin
        npc = pc;
        case (op)
            OP_BEQ:   if (alu_zero)  npc = pc + ADDR_W'(imm_sext);
            OP_BNE:   if (!alu_zero) npc = pc + ADDR_W'(imm_sext);
            OP_J,
            OP_JAL:   npc = ir[ADDR_W-1:0];
            OP_RTYPE: if (funct == FN_JR) npc = a_reg[ADDR_W-1:0];
            default:  ;
        endcase
    end

    always_comb begin
        wb_idx = rt;
        if (op == OP_RTYPE)
            wb_idx = rd;
        else if (op == OP_JAL)
            wb_idx = LINK_REG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FETCH;
            pc            <= RST_PC;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            display       <= '0;
            display_valid <= 1'b0;
            halted        <= 1'b0;
`ifdef OVF_TRAP_EN
            ovf           <= 1'b0;
`endif
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            display_valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (mem_req) begin
                        if (mem_ready) begin
                            ir      <= 32'(mem_rdata);
                            mem_req <= 1'b0;
                            state   <= DECODE;
                        end
                    end else if (!halt) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                DECODE: begin
                    a_reg <= rf_read(rs);
                    b_reg <= rf_read(rt);
                    pc    <= pc + 1'b1;
                    // Display is loaded here so the pulse lands in OUT's EXEC cycle.
                    if (op == OP_OUT) begin
                        display       <= rf_read(rs);
                        display_valid <= 1'b1;
                    end
                    state <= EXEC;
                end
                EXEC: begin
                    case (op)
                        OP_RTYPE, OP_ADDI: begin
                            if (op == OP_ADDI || r_alu) begin
                                res   <= alu_y;
                                state <= WB;
`ifdef OVF_TRAP_EN
                                if (alu_ovf) begin
                                    state  <= STOP;
                                    halted <= 1'b1;
                                    ovf    <= 1'b1;
                                end
`endif
                            end else begin
                                pc       <= npc;
                                state    <= FETCH;
                                mem_req  <= !halt;
                                mem_we   <= 1'b0;
                                mem_addr <= npc;
                            end
                        end
                        OP_IN: begin
                            res   <= DATA_W'(switches);
                            state <= WB;
                        end
                        OP_JAL: begin
                            res   <= DATA_W'(pc);
                            pc    <= npc;
                            state <= WB;
                        end
                        OP_LW, OP_SW: begin
                            mem_req   <= 1'b1;
                            mem_we    <= (op == OP_SW);
                            mem_addr  <= ADDR_W'(a_reg + imm_sext);
                            mem_wdata <= b_reg;
                            state     <= MEM;
                        end
                        OP_HLT: begin
                            state  <= STOP;
                            halted <= 1'b1;
                        end
                        default: begin
                            pc       <= npc;
                            state    <= FETCH;
                            mem_req  <= !halt;
                            mem_we   <= 1'b0;
                            mem_addr <= npc;
                        end
                    endcase
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (op == OP_LW) begin
                            res     <= mem_rdata;
                            mem_req <= 1'b0;
                            state   <= WB;
                        end else begin
                            state    <= FETCH;
                            mem_req  <= !halt;
                            mem_addr <= pc;
                        end
                    end
                end
                WB: begin
                    if (wb_idx != 5'd0 && int'(wb_idx) < NREGS)
                        regs[wb_idx] <= res;
                    state    <= FETCH;
                    mem_req  <= !halt;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end
                STOP: ;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: a memory responder with programmable
// wait states, display/store queues and fetch-interval CPI checks.
module tb_multicycle_cpu;

    logic        clk, reset, halt;
    logic        mem_req, mem_we, mem_ready;
    logic [15:0] mem_addr, switches, pc;
    logic [31:0] mem_wdata, mem_rdata, display;
    logic        display_valid, halted;
`ifdef OVF_TRAP_EN
    logic        ovf;
`endif

    multicycle_cpu dut (
        .clk           (clk),
        .reset         (reset),
        .halt          (halt),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .switches      (switches),
        .display       (display),
        .display_valid (display_valid),
        .pc            (pc),
        .halted        (halted)
`ifdef OVF_TRAP_EN
        ,
        .ovf           (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] mem [0:255];
    logic [31:0] disp_q [$];
    logic [47:0] wr_q [$];
    int          fetch_t [$];
    logic [15:0] fetch_a [$];
    int          wait_cyc, wcnt, cyc, stab_err, disp_cnt;
    logic        waiting, cap_we;
    logic [15:0] cap_addr;
    logic [31:0] cap_wd;

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs_i,
                                          input logic [4:0] rt_i, input logic [4:0] rd_i,
                                          input logic [4:0] sh);
        return {6'h00, rs_i, rt_i, rd_i, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs_i,
                                          input logic [4:0] rt_i, input logic [15:0] im);
        return {opc, rs_i, rt_i, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] tgt);
        return {opc, tgt};
    endfunction

    // Memory responder plus output monitors, all evaluated on the falling edge.
    initial begin
        mem_ready = 1'b0; mem_rdata = '0; wcnt = 0; waiting = 1'b0; cyc = 0;
        cap_we = 1'b0; cap_addr = '0; cap_wd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (display_valid) begin
                disp_cnt++;
                if (disp_q.size() > 0) check("display", display, disp_q.pop_front());
                else check("disp_q_nonempty", disp_q.size(), 1);
            end
            if (reset) begin
                mem_ready = 1'b0; wcnt = 0; waiting = 1'b0;
            end else if (mem_req) begin
                if (waiting && (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wd))
                    stab_err++;
                if (!waiting) begin
                    cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
                end
                if (wcnt >= wait_cyc) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[7:0]] = mem_wdata;
                        if (wr_q.size() > 0) check("mem_write", {mem_addr, mem_wdata}, wr_q.pop_front());
                        else check("wr_q_nonempty", wr_q.size(), 1);
                    end else begin
                        mem_rdata = mem[mem_addr[7:0]];
                        if (mem_addr < 16'h40) begin
                            fetch_t.push_back(cyc);
                            fetch_a.push_back(mem_addr);
                        end
                    end
                    wcnt = 0; waiting = 1'b0;
                end else begin
                    mem_ready = 1'b0; wcnt++; waiting = 1'b1;
                end
            end else begin
                if (waiting) stab_err++;
                mem_ready = 1'b0; wcnt = 0; waiting = 1'b0;
            end
        end
    end

    task automatic prep(input int w);
        reset = 1'b1;
        wait_cyc = w;
        @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] = '0;
        disp_q.delete(); wr_q.delete(); fetch_t.delete(); fetch_a.delete();
        stab_err = 0; disp_cnt = 0;
    endtask

    task automatic go();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_halted(input int max);
        int n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            n++;
        end
        check("halted_reached", halted, 1'b1);
    endtask

    task automatic chk_cpi(input string tag, input int idx, input int exp);
        if (fetch_t.size() > idx + 1) check(tag, fetch_t[idx+1] - fetch_t[idx], exp);
        else check({tag, "_missing"}, fetch_t.size(), idx + 2);
    endtask

    task automatic load_arith();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[2] = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        mem[3] = enc_i(6'h3D, 5'd3, 5'd0, 16'd0);
        mem[4] = enc_j(6'h3F, 26'd0);
        disp_q.push_back(32'd2);
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0; switches = 16'hA5C3; wait_cyc = 0;
        stab_err = 0; disp_cnt = 0;
        @(negedge clk); @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_pc", pc, 16'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_display", display, 32'h0);
        check("rst_display_valid", display_valid, 1'b0);

        // Arithmetic + OUT with zero-wait memory, then with 3 wait states.
        for (int w = 0; w <= 3; w += 3) begin
            prep(w);
            load_arith();
            go();
            wait_halted(300);
            chk_cpi("cpi_addi1", 0, 4 + w);
            chk_cpi("cpi_addi2", 1, 4 + w);
            chk_cpi("cpi_add", 2, 4 + w);
            chk_cpi("cpi_out", 3, 3 + w);
            check("disp_pulses", disp_cnt, 1);
            check("disp_left", disp_q.size(), 0);
            check("req_stable", stab_err, 0);
            repeat (3) @(negedge clk);
            check("halted_held", halted, 1'b1);
            check("halt_pc", pc, 16'd5);
            check("halt_no_req", mem_req, 1'b0);
        end

        // Store then load through the shared port.
        prep(0);
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0040);
        mem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'h0040);
        mem[3] = enc_i(6'h3D, 5'd4, 5'd0, 16'd0);
        mem[4] = enc_j(6'h3F, 26'd0);
        wr_q.push_back({16'h0040, 32'd5});
        disp_q.push_back(32'd5);
        go();
        wait_halted(300);
        chk_cpi("cpi_sw", 1, 4);
        chk_cpi("cpi_lw", 2, 5);
        check("wr_left", wr_q.size(), 0);
        check("ld_disp_left", disp_q.size(), 0);

        // J into a BEQ that branches back onto itself.
        prep(0);
        mem[0]     = enc_j(6'h02, 26'h10);
        mem[8'h10] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        go();
        for (int n = 0; n < 100 && fetch_a.size() < 4; n++) @(negedge clk);
        check("loop_fetches", fetch_a.size() >= 4, 1'b1);
        if (fetch_a.size() >= 4) begin
            check("j_target", fetch_a[1], 16'h10);
            check("beq_back1", fetch_a[2], 16'h10);
            check("beq_back2", fetch_a[3], 16'h10);
        end
        chk_cpi("cpi_j", 0, 3);
        chk_cpi("cpi_beq", 1, 3);

        // BNE not taken, JAL link, SLT/SLL/SUB/IN/AND/OR, r0 write, JR.
        prep(0);
        mem[0]     = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        mem[1]     = enc_i(6'h05, 5'd1, 5'd1, 16'd5);
        mem[2]     = enc_j(6'h03, 26'h20);
        mem[8'h20] = enc_i(6'h3D, 5'd31, 5'd0, 16'd0);
        mem[8'h21] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[8'h22] = enc_r(6'h2A, 5'd2, 5'd1, 5'd5, 5'd0);
        mem[8'h23] = enc_i(6'h3D, 5'd5, 5'd0, 16'd0);
        mem[8'h24] = enc_r(6'h00, 5'd0, 5'd1, 5'd6, 5'd4);
        mem[8'h25] = enc_i(6'h3D, 5'd6, 5'd0, 16'd0);
        mem[8'h26] = enc_r(6'h22, 5'd2, 5'd1, 5'd7, 5'd0);
        mem[8'h27] = enc_i(6'h3D, 5'd7, 5'd0, 16'd0);
        mem[8'h28] = enc_i(6'h3C, 5'd0, 5'd9, 16'd0);
        mem[8'h29] = enc_i(6'h3D, 5'd9, 5'd0, 16'd0);
        mem[8'h2A] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        mem[8'h2B] = enc_i(6'h3D, 5'd0, 5'd0, 16'd0);
        mem[8'h2C] = enc_i(6'h08, 5'd0, 5'd8, 16'h0030);
        mem[8'h2D] = enc_r(6'h08, 5'd8, 5'd0, 5'd0, 5'd0);
        mem[8'h2E] = enc_i(6'h3D, 5'd8, 5'd0, 16'd0);
        mem[8'h30] = enc_r(6'h24, 5'd2, 5'd1, 5'd10, 5'd0);
        mem[8'h31] = enc_r(6'h25, 5'd2, 5'd1, 5'd11, 5'd0);
        mem[8'h32] = enc_i(6'h3D, 5'd10, 5'd0, 16'd0);
        mem[8'h33] = enc_i(6'h3D, 5'd11, 5'd0, 16'd0);
        mem[8'h34] = enc_j(6'h3F, 26'd0);
        disp_q.push_back(32'd3);
        disp_q.push_back(32'd1);
        disp_q.push_back(32'd16);
        disp_q.push_back(32'hFFFF_FFFC);
        disp_q.push_back(32'h0000_A5C3);
        disp_q.push_back(32'd0);
        disp_q.push_back(32'd1);
        disp_q.push_back(32'hFFFF_FFFD);
        go();
        wait_halted(600);
        if (fetch_a.size() >= 4) begin
            check("bne_not_taken", fetch_a[2], 16'h2);
            check("jal_target", fetch_a[3], 16'h20);
        end else check("branch_fetches", fetch_a.size(), 4);
        chk_cpi("cpi_bne", 1, 3);
        chk_cpi("cpi_jal", 2, 4);
        check("misc_disp_left", disp_q.size(), 0);

        // Signed overflow on ADD: 0x7FFFFFFF + 1.
        prep(0);
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
        mem[1] = enc_r(6'h02, 5'd0, 5'd1, 5'd1, 5'd1);
        mem[2] = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
        mem[3] = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        mem[4] = enc_i(6'h3D, 5'd3, 5'd0, 16'd0);
        mem[5] = enc_j(6'h3F, 26'd0);
`ifndef OVF_TRAP_EN
        disp_q.push_back(32'h8000_0000);
`endif
        go();
        wait_halted(300);
`ifdef OVF_TRAP_EN
        check("ovf_flag", ovf, 1'b1);
        check("ovf_pc", pc, 16'd4);
`endif
        check("ovf_disp_left", disp_q.size(), 0);

        // Reset pulse while a load is waiting on memory.
        prep(6);
        mem[0] = enc_i(6'h23, 5'd0, 5'd4, 16'h0040);
        go();
        for (int n = 0; n < 60 && !(mem_req && mem_addr == 16'h0040); n++) @(negedge clk);
        check("lw_req_seen", mem_req && mem_addr == 16'h0040, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_mem_req", mem_req, 1'b0);
        check("mid_rst_mem_we", mem_we, 1'b0);
        check("mid_rst_pc", pc, 16'h0);
        check("mid_rst_halted", halted, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
